// File: rtl/button_event_arbiter.sv
// Classifies debounced button levels into SHORT/LONG/REPEAT events and merges them into
// one valid/ready event stream using round-robin arbitration over one-deep per-button slots.
module button_event_arbiter #(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned CLK_HZ          = 16_000_000,
   parameter int unsigned Simulacion      = 0,
   parameter int unsigned TICK_CYCLES_SIM = 4,
   parameter int unsigned LONG_MS         = 500,
   parameter int unsigned REPEAT_MS       = 150
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] pressed_i,
   output logic             evt_valid_o,
   input  logic             evt_ready_i,
   output logic [2:0]       evt_btn_o,
   output logic [1:0]       evt_type_o,
   output logic [N_BTN-1:0] ovf_o,
   input  logic             ovf_clear_i
);

   localparam int unsigned TickDiv = (Simulacion != 0) ? TICK_CYCLES_SIM : CLK_HZ / 1000;
   localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam int unsigned HoldMax = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int unsigned CntW    = $clog2(HoldMax) + 1;

   localparam logic [PreW-1:0] PreLast  = PreW'(TickDiv - 1);
   localparam logic [CntW-1:0] LongLast = CntW'(LONG_MS - 1);
   localparam logic [CntW-1:0] RptLast  = CntW'(REPEAT_MS - 1);

   localparam logic [1:0] EvtShort  = 2'd0;
   localparam logic [1:0] EvtLong   = 2'd1;
   localparam logic [1:0] EvtRepeat = 2'd2;

   typedef enum logic [1:0] {StIdle, StHeld, StRpt} state_e;

   logic [PreW-1:0]  pre_q, pre_d;
   logic             tick;
   logic [N_BTN-1:0] prev_q, armed_q, armed_d, rise;
   state_e           state_q [N_BTN];
   state_e           state_d [N_BTN];
   logic [CntW-1:0]  cnt_q [N_BTN];
   logic [CntW-1:0]  cnt_d [N_BTN];
   logic [N_BTN-1:0] emit;
   logic [1:0]       emit_type [N_BTN];

   logic [N_BTN-1:0] slot_full_q, slot_full_d;
   logic [1:0]       slot_type_q [N_BTN];
   logic [1:0]       slot_type_d [N_BTN];
   logic [N_BTN-1:0] ovf_q, ovf_d, gnt;
   logic             valid_q, valid_d, load, found_hi, found_lo;
   logic [2:0]       btn_q, btn_d, rr_q, rr_d, idx_hi, idx_lo, gnt_idx;
   logic [1:0]       type_q, type_d, gnt_type;

   // A button held through reset release must be seen released before a press counts.
   assign rise    = pressed_i & ~prev_q & armed_q;
   assign armed_d = armed_q | ~pressed_i;

   always_comb begin
      tick  = (pre_q == PreLast);
      pre_d = tick ? '0 : pre_q + PreW'(1);
   end

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         state_d[i]   = state_q[i];
         cnt_d[i]     = cnt_q[i];
         emit[i]      = 1'b0;
         emit_type[i] = EvtShort;
         case (state_q[i])
            StIdle: begin
               if (rise[i]) begin
                  state_d[i] = StHeld;
                  cnt_d[i]   = '0;
               end
            end
            StHeld: begin
               if (!pressed_i[i]) begin
                  emit[i]    = 1'b1;
                  state_d[i] = StIdle;
               end else if (tick) begin
                  if (cnt_q[i] == LongLast) begin
                     emit[i]      = 1'b1;
                     emit_type[i] = EvtLong;
                     state_d[i]   = StRpt;
                     cnt_d[i]     = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CntW'(1);
                  end
               end
            end
            StRpt: begin
               if (!pressed_i[i]) begin
                  state_d[i] = StIdle;
               end else if (REPEAT_MS != 0 && tick) begin
                  if (cnt_q[i] == RptLast) begin
                     emit[i]      = 1'b1;
                     emit_type[i] = EvtRepeat;
                     cnt_d[i]     = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CntW'(1);
                  end
               end
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   // Round-robin: first full slot above the last grant wins, else the lowest full slot.
   always_comb begin
      load     = (!valid_q || evt_ready_i) && (|slot_full_q);
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (slot_full_q[i]) begin
            if (i > int'(rr_q)) begin
               if (!found_hi) begin
                  found_hi = 1'b1;
                  idx_hi   = 3'(i);
               end
            end else if (!found_lo) begin
               found_lo = 1'b1;
               idx_lo   = 3'(i);
            end
         end
      end
      gnt_idx  = found_hi ? idx_hi : idx_lo;
      gnt_type = EvtShort;
      for (int i = 0; i < N_BTN; i++) begin
         gnt[i] = load && (3'(i) == gnt_idx);
         if (3'(i) == gnt_idx) gnt_type = slot_type_q[i];
      end
   end

   always_comb begin
      ovf_d = ovf_clear_i ? '0 : ovf_q;
      for (int i = 0; i < N_BTN; i++) begin
         slot_full_d[i] = slot_full_q[i] & ~gnt[i];
         slot_type_d[i] = slot_type_q[i];
         if (emit[i]) begin
            if (slot_full_d[i]) begin
               ovf_d[i] = 1'b1;
            end else begin
               slot_full_d[i] = 1'b1;
               slot_type_d[i] = emit_type[i];
            end
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      btn_d   = btn_q;
      type_d  = type_q;
      rr_d    = rr_q;
      if (!valid_q || evt_ready_i) begin
         valid_d = load;
         if (load) begin
            btn_d  = gnt_idx;
            type_d = gnt_type;
            rr_d   = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q       <= '0;
         prev_q      <= '0;
         armed_q     <= '0;
         slot_full_q <= '0;
         ovf_q       <= '0;
         valid_q     <= 1'b0;
         btn_q       <= '0;
         type_q      <= '0;
         rr_q        <= 3'(N_BTN - 1);
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i]     <= StIdle;
            cnt_q[i]       <= '0;
            slot_type_q[i] <= '0;
         end
      end else begin
         pre_q       <= pre_d;
         prev_q      <= pressed_i;
         armed_q     <= armed_d;
         slot_full_q <= slot_full_d;
         ovf_q       <= ovf_d;
         valid_q     <= valid_d;
         btn_q       <= btn_d;
         type_q      <= type_d;
         rr_q        <= rr_d;
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i]     <= state_d[i];
            cnt_q[i]       <= cnt_d[i];
            slot_type_q[i] <= slot_type_d[i];
         end
      end
   end

   assign evt_valid_o = valid_q;
   assign evt_btn_o   = btn_q;
   assign evt_type_o  = type_q;
   assign ovf_o       = ovf_q;

endmodule
